// File: rtl/adc_capture_pkg.sv
// Shared types and default widths for the ADC capture write sequencer.
package adc_capture_pkg;

    localparam int unsigned ADC_PRECISION        = 10;
    localparam int unsigned ADC_COUNT_WIDTH      = 16;
    localparam int unsigned ADC_DECIM_WIDTH      = 8;
    localparam int unsigned ADC_FIFO_COUNT_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE,
        DISCARD,
        CAPTURE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/adc_decim_strobe.sv
// Decimation phase counter: strobes on count 0 and wraps after cfg_decim.
module adc_decim_strobe
    import adc_capture_pkg::*;
#(
    parameter int unsigned DECIM_WIDTH = ADC_DECIM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [DECIM_WIDTH-1:0] cfg_decim,
    output logic                   strobe_c
);

    logic [DECIM_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == cfg_decim) ? '0 : cnt + DECIM_WIDTH'(1);
        end
    end

    assign strobe_c = enable && (cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Host-armed ADC capture sequencer: settling discard, decimation and
// overflow detection in front of the capture FIFO write port.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned PRECISION        = ADC_PRECISION,
    parameter int unsigned FIFO_COUNT_WIDTH = ADC_FIFO_COUNT_WIDTH,
    parameter logic [FIFO_COUNT_WIDTH-1:0] OVERFLOW_THRESHOLD = {FIFO_COUNT_WIDTH{1'b1}},
    parameter int unsigned COUNT_WIDTH      = ADC_COUNT_WIDTH,
    parameter int unsigned DECIM_WIDTH      = ADC_DECIM_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm,
    input  logic                        abort,
    input  logic [COUNT_WIDTH-1:0]      cfg_num_samples,
    input  logic [COUNT_WIDTH-1:0]      cfg_discard,
    input  logic [DECIM_WIDTH-1:0]      cfg_decim,
    input  logic [PRECISION-1:0]        adc_code_in,
    input  logic                        fifo_full,
    input  logic [FIFO_COUNT_WIDTH-1:0] wr_data_count,
    output logic                        wr_en,
    output logic [PRECISION-1:0]        wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow_err,
    output logic [COUNT_WIDTH-1:0]      samples_written
);

    state_t                   state, state_nxt;
    logic [COUNT_WIDTH-1:0]   num_lat, num_nxt;
    logic [COUNT_WIDTH-1:0]   disc_lat, disc_nxt;
    logic [DECIM_WIDTH-1:0]   decim_lat, decim_nxt;
    logic [COUNT_WIDTH-1:0]   disc_cnt, disc_cnt_nxt;
    logic [COUNT_WIDTH-1:0]   sw_nxt;
    logic [PRECISION-1:0]     wr_data_nxt;
    logic                     wr_en_nxt, busy_nxt, done_nxt, ovf_nxt;
    logic                     strobe_c;
    logic                     ovf_hit_c;

    adc_decim_strobe #(
        .DECIM_WIDTH (DECIM_WIDTH)
    ) u_decim (
        .clk       (clk),
        .rst       (rst),
        .clear     (state != CAPTURE),
        .enable    (state == CAPTURE),
        .cfg_decim (decim_lat),
        .strobe_c  (strobe_c)
    );

    assign ovf_hit_c = fifo_full || (wr_data_count >= OVERFLOW_THRESHOLD);

    // Next-state and next-output logic; abort overrides everything including arm.
    always_comb begin
        state_nxt    = state;
        num_nxt      = num_lat;
        disc_nxt     = disc_lat;
        decim_nxt    = decim_lat;
        disc_cnt_nxt = disc_cnt;
        sw_nxt       = samples_written;
        wr_data_nxt  = wr_data;
        wr_en_nxt    = 1'b0;
        done_nxt     = done;
        ovf_nxt      = overflow_err;

        if (abort) begin
            state_nxt    = IDLE;
            done_nxt     = 1'b0;
            ovf_nxt      = 1'b0;
            disc_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (arm) begin
                        num_nxt      = cfg_num_samples;
                        disc_nxt     = cfg_discard;
                        decim_nxt    = cfg_decim;
                        disc_cnt_nxt = '0;
                        sw_nxt       = '0;
                        done_nxt     = 1'b0;
                        ovf_nxt      = 1'b0;
                        state_nxt    = (cfg_discard == '0) ? CAPTURE : DISCARD;
                    end
                end
                DISCARD: begin
                    if (disc_cnt + COUNT_WIDTH'(1) == disc_lat) begin
                        disc_cnt_nxt = '0;
                        state_nxt    = CAPTURE;
                    end else begin
                        disc_cnt_nxt = disc_cnt + COUNT_WIDTH'(1);
                    end
                end
                CAPTURE: begin
                    // Only reachable with a zero-length request; normal runs leave on the last write.
                    if (samples_written == num_lat) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (strobe_c) begin
                        if (ovf_hit_c) begin
                            state_nxt = ERR;
                            ovf_nxt   = 1'b1;
                        end else begin
                            wr_en_nxt   = 1'b1;
                            wr_data_nxt = adc_code_in;
                            sw_nxt      = samples_written + COUNT_WIDTH'(1);
                            if (samples_written + COUNT_WIDTH'(1) == num_lat) begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt == DISCARD) || (state_nxt == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            num_lat         <= '0;
            disc_lat        <= '0;
            decim_lat       <= '0;
            disc_cnt        <= '0;
            samples_written <= '0;
            wr_data         <= '0;
            wr_en           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow_err    <= 1'b0;
        end else begin
            state           <= state_nxt;
            num_lat         <= num_nxt;
            disc_lat        <= disc_nxt;
            decim_lat       <= decim_nxt;
            disc_cnt        <= disc_cnt_nxt;
            samples_written <= sw_nxt;
            wr_data         <= wr_data_nxt;
            wr_en           <= wr_en_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            overflow_err    <= ovf_nxt;
        end
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences writes of ADC codes into the capture FIFO in the ADC clock domain.
- Replaces the free-running write enable with a host-armed capture of a programmed length.
- Supports discarding settling samples, decimation, and overflow detection.
- Sits between the ADC code input and the FIFO write port. Config and arm/abort arrive already synchronised into this clock domain.

Parameters:
- PRECISION, 10, ADC code width.
- FIFO_COUNT_WIDTH, 12, width of FIFO wr_data_count.
- OVERFLOW_THRESHOLD, {FIFO_COUNT_WIDTH{1'b1}}, write-side fill level treated as overflow.
- COUNT_WIDTH, 16, width of sample and discard counters.
- DECIM_WIDTH, 8, width of decimation setting.

Ports:
- clk  in  1  ADC sample clock (wire this to adc_clk); single clock of the block.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle start request.
- abort  in  1  single-cycle stop request.
- cfg_num_samples  in  COUNT_WIDTH  number of samples to write.
- cfg_discard  in  COUNT_WIDTH  number of leading samples dropped after arm.
- cfg_decim  in  DECIM_WIDTH  write 1 of every cfg_decim+1 samples.
- adc_code_in  in  PRECISION  ADC code, valid every clk.
- fifo_full  in  1  FIFO full flag (write side).
- wr_data_count  in  FIFO_COUNT_WIDTH  FIFO write-side fill count.
- wr_en  out  1  FIFO write enable.
- wr_data  out  PRECISION  FIFO din.
- busy  out  1  high in DISCARD or CAPTURE.
- done  out  1  capture completed normally.
- overflow_err  out  1  sticky overflow indication.
- samples_written  out  COUNT_WIDTH  writes issued since the last arm.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; internal counters are 0.
- States: IDLE, DISCARD, CAPTURE, DONE, ERR.
- arm in IDLE, DONE or ERR:
  - Latch all cfg_* values.
  - Clear done, overflow_err and samples_written.
  - Go to DISCARD; if cfg_discard==0, go straight to CAPTURE.
- arm in DISCARD or CAPTURE is ignored.
- DISCARD: one sample dropped per clk. After exactly cfg_discard cycles in DISCARD, go to CAPTURE.
- CAPTURE: the decimation counter runs from 0 to cfg_decim and wraps. A sample is eligible on the first CAPTURE cycle and then every cfg_decim+1 cycles. cfg_decim==0 means every cycle.
- Eligible sample, no overflow:
  - Next cycle: wr_en=1 and wr_data = that cycle's adc_code_in (1-cycle registered latency).
  - samples_written increments.
- When samples_written reaches the latched cfg_num_samples, go to DONE and set done=1. The last wr_en pulse coincides with the DONE transition cycle.
- cfg_num_samples==0: CAPTURE goes to DONE on its first cycle with no write.
- Overflow: an eligible sample with fifo_full=1 or wr_data_count>=OVERFLOW_THRESHOLD:
  - No write is issued.
  - Go to ERR and set overflow_err=1.
  - overflow_err holds until the next accepted arm or rst.
- DONE and ERR hold until arm.
- abort from any state:
  - Go to IDLE next cycle; wr_en is 0 from that cycle.
  - done and overflow_err are cleared; samples_written is preserved.
- arm and abort in the same cycle: abort wins.
- rst mid-capture: immediate return to reset values on the next edge; no partial write.
- Counters never wrap. The comparison uses the latched config, so cfg_* changes during a capture have no effect.
- wr_en is never asserted outside the cycle following an eligible CAPTURE sample.

Decomposition:
- Package adc_capture_pkg:
  - State enum (IDLE, DISCARD, CAPTURE, DONE, ERR).
  - Default width constants (PRECISION, COUNT_WIDTH, DECIM_WIDTH, FIFO_COUNT_WIDTH).
- One sub-module, adc_decim_strobe:
  - Inputs: clear, enable, cfg_decim.
  - Output: a strobe on count 0, with synchronous wrap.
- The FSM, counters and output register stay in the top module.

Test Plan:
1. rst, then arm with num=8, discard=0, decim=0, ramp input 0,1,2... -> exactly 8 consecutive wr_en pulses, wr_data = the 8 codes sampled in CAPTURE, done=1, samples_written=8, busy=0.
2. num=4, discard=3, decim=2 -> first 3 samples dropped; writes carry samples at CAPTURE cycles 0,3,6,9; wr_en spacing is 3 clocks; done after the 4th write.
3. num=100, force wr_data_count=4095 at the 10th eligible sample -> 9 writes, no 10th write, overflow_err=1, state ERR; a following arm clears it.
4. num=50, abort at the 20th write, and a simultaneous arm+abort test -> wr_en low from the next cycle, state IDLE, done=0; the arm is not honoured.
5. num=0 -> no wr_en, done=1 within discard+1 cycles. A second arm during CAPTURE of a num=16 run -> ignored, exactly 16 writes.
6. rst asserted mid-CAPTURE -> next cycle all outputs 0, state IDLE; a new arm then captures normally.
